// File: rtl/sh_wdt_multi_if.sv
// Internal peripheral bus (IBUS) bundle between a bus master and the watchdog block.
// The master drives address, data and strobes; the slave answers with read data and status.
interface sh_wdt_multi_if;
  logic [31:0] a;
  logic [31:0] di;
  logic [31:0] dout;
  logic        we;
  logic        req;
  logic        busy;
  logic        act;

  modport master (output a, di, we, req, input dout, busy, act);
  modport slave  (input a, di, we, req, output dout, busy, act);
endinterface

// File: rtl/sh_wdt_multi.sv
// Multi-channel SH-2 style watchdog / interval timer sharing one 13-bit prescaler.
// Each channel is an up-counter with its own CSR; watchdog overflows drive shared reset pulses.
module sh_wdt_multi #(
  parameter int unsigned Channels = 2,
  parameter int unsigned CntW     = 8,
  parameter logic [31:0] Base     = 32'hFFFFFE80,
  parameter int unsigned OvfPulse = 128,
  parameter int unsigned ResPulse = 512,
  parameter bit          Disable  = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                ce_r_i,
  input  logic                en_i,
  input  logic                res_ni,
  input  logic                sby_i,
  sh_wdt_multi_if.slave       ibus,
  output logic [Channels-1:0] iti_irq_o,
  output logic                wdtovf_no,
  output logic                pres_o,
  output logic                mres_o
);

  localparam int unsigned OvfW = $clog2(OvfPulse + 1);
  localparam int unsigned ResW = $clog2(ResPulse + 1);
  localparam logic [31:0] Span = 32'(Channels * 16);

  logic            en_cyc;
  logic [12:0]     pre_q, pre_d;
  logic [CntW-1:0] cnt_q [Channels];
  logic [CntW-1:0] cnt_d [Channels];
  logic [7:0]      csr_q [Channels];
  logic [7:0]      csr_d [Channels];
  logic [Channels-1:0] wovf_q, wovf_d;
  logic [OvfW-1:0] ovf_cnt_q, ovf_cnt_d;
  logic [ResW-1:0] res_cnt_q, res_cnt_d;
  logic            rsts_q, rsts_d;
  logic [31:0]     dout_q, dout_d;

  logic [31:0] off;
  logic        hit;
  logic [1:0]  sel_ch;
  logic        wr_en;
  logic [7:0]  key;
  logic        wd_evt;
  logic        rst_evt;
  logic        unused_di;

  assign en_cyc    = ce_r_i & en_i & ~Disable;
  assign off       = ibus.a - Base;
  assign hit       = (off < Span);
  assign sel_ch    = off[5:4];
  assign key       = ibus.di[31:24];
  assign wr_en     = en_cyc & ibus.req & ibus.we & hit & (ibus.a[3:2] == 2'd0);
  assign unused_di = ^ibus.di[23:8];

  // Tick when the low log2(divisor) prescaler bits are all ones.
  function automatic logic tick_of(input logic [12:0] p, input logic [2:0] cks);
    logic t;
    case (cks)
      3'd0:    t = p[0];
      3'd1:    t = &p[5:0];
      3'd2:    t = &p[6:0];
      3'd3:    t = &p[7:0];
      3'd4:    t = &p[8:0];
      3'd5:    t = &p[9:0];
      3'd6:    t = &p[11:0];
      default: t = &p[12:0];
    endcase
    return t;
  endfunction

  always_comb begin
    wd_evt  = 1'b0;
    rst_evt = 1'b0;
    rsts_d  = rsts_q;
    wovf_d  = wovf_q;
    pre_d   = en_cyc ? pre_q + 13'd1 : pre_q;
    for (int unsigned c = 0; c < Channels; c++) begin
      cnt_d[c] = cnt_q[c];
      csr_d[c] = csr_q[c];
      if (en_cyc && !sby_i && csr_q[c][5] && tick_of(pre_q, csr_q[c][2:0])) begin
        cnt_d[c] = cnt_q[c] + 1'b1;
        if (&cnt_q[c]) begin
          if (csr_q[c][6]) begin
            wovf_d[c]   = 1'b1;
            csr_d[c][5] = 1'b0;
            wd_evt      = 1'b1;
            if (csr_q[c][4]) begin
              rst_evt = 1'b1;
              rsts_d  = csr_q[c][3];
            end
          end else begin
            csr_d[c][7] = 1'b1;
          end
        end
      end
      // Bus writes override count/overflow results only for the fields they touch.
      if (wr_en && sel_ch == 2'(c)) begin
        case (key)
          8'h5A: cnt_d[c] = ibus.di[CntW-1:0];
          8'hA5: begin
            csr_d[c][6:0] = ibus.di[6:0];
            if (!ibus.di[7]) csr_d[c][7] = 1'b0;
            if (!ibus.di[5]) begin
              cnt_d[c]    = '0;
              csr_d[c][7] = 1'b0;
            end
          end
          8'hC3: if (!ibus.di[0]) wovf_d[c] = 1'b0;
          default: ;
        endcase
      end
      if (sby_i) begin
        cnt_d[c]      = '0;
        csr_d[c][7:3] = '0;
        wovf_d[c]     = 1'b0;
      end
      if (!res_ni) begin
        cnt_d[c] = '0;
        csr_d[c] = '0;
      end
    end

    ovf_cnt_d = ovf_cnt_q;
    if (en_cyc && ovf_cnt_q != '0) ovf_cnt_d = ovf_cnt_q - 1'b1;
    if (wd_evt) ovf_cnt_d = OvfW'(OvfPulse);
    res_cnt_d = res_cnt_q;
    if (en_cyc && res_cnt_q != '0) res_cnt_d = res_cnt_q - 1'b1;
    if (rst_evt) res_cnt_d = ResW'(ResPulse);

    if (!res_ni) begin
      pre_d     = '0;
      wovf_d    = '0;
      ovf_cnt_d = '0;
      res_cnt_d = '0;
      rsts_d    = 1'b0;
    end
  end

  // Read data is registered on any CE_R cycle, independent of EN.
  always_comb begin
    dout_d = dout_q;
    if (ce_r_i && ibus.req && !ibus.we) begin
      dout_d = '0;
      if (hit && !Disable) begin
        for (int unsigned c = 0; c < Channels; c++) begin
          if (sel_ch == 2'(c)) begin
            case (ibus.a[3:2])
              2'd0:    dout_d = {8'h00, csr_q[c], 16'(cnt_q[c])};
              2'd1:    dout_d = {31'b0, wovf_q[c]};
              default: dout_d = '0;
            endcase
          end
        end
      end
    end
    if (!res_ni) dout_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_q     <= '0;
      wovf_q    <= '0;
      ovf_cnt_q <= '0;
      res_cnt_q <= '0;
      rsts_q    <= 1'b0;
      dout_q    <= '0;
      for (int unsigned c = 0; c < Channels; c++) begin
        cnt_q[c] <= '0;
        csr_q[c] <= '0;
      end
    end else begin
      pre_q     <= pre_d;
      wovf_q    <= wovf_d;
      ovf_cnt_q <= ovf_cnt_d;
      res_cnt_q <= res_cnt_d;
      rsts_q    <= rsts_d;
      dout_q    <= dout_d;
      for (int unsigned c = 0; c < Channels; c++) begin
        cnt_q[c] <= cnt_d[c];
        csr_q[c] <= csr_d[c];
      end
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < Channels; c++) begin
      iti_irq_o[c] = csr_q[c][7] & ~csr_q[c][6];
    end
  end

  // Gating with res_ni drops the pulses in the same cycle the chip reset arrives.
  assign wdtovf_no = ~(|ovf_cnt_q) | ~res_ni;
  assign pres_o    = (|res_cnt_q) & ~rsts_q & res_ni;
  assign mres_o    = (|res_cnt_q) & rsts_q & res_ni;
  assign ibus.dout = dout_q;
  assign ibus.busy = 1'b0;
  assign ibus.act  = hit;

endmodule
